// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: two requesters sharing one synchronous single-port memory, one transfer per cycle.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 always wins.
module mem_arbiter_2p #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_Data_in,
    output logic              mem_W_EN,
    input  logic [DATA_W-1:0] mem_Data_out
);
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              r_w_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_s1_v;
    logic              r_s1_id;
    logic              r_s2_v;
    logic              r_s2_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // r_prio=1 favours port 1; it points away from whichever port won the last transfer
    logic r_prio;
    assign w_gnt0 = !RST && req0 && (!req1 || !r_prio);
    assign w_gnt1 = !RST && req1 && (!req0 || r_prio);
    always_ff @(posedge CLK) begin
        if (RST)
            r_prio <= 1'b0;
        else if (w_xfer)
            r_prio <= w_gnt0;
    end
`else
    assign w_gnt0 = !RST && req0;
    assign w_gnt1 = !RST && req1 && !req0;
`endif

    assign w_xfer  = w_gnt0 || w_gnt1;
    assign w_we    = w_gnt1 ? we1 : we0;
    assign w_addr  = w_gnt1 ? addr1 : addr0;
    assign w_wdata = w_gnt1 ? wdata1 : wdata0;

    // Stage 1 tracks the read in the memory's address register, stage 2 the cycle Data_out holds it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_w_en  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_s1_v  <= 1'b0;
            r_s1_id <= 1'b0;
            r_s2_v  <= 1'b0;
            r_s2_id <= 1'b0;
        end else begin
            r_w_en  <= w_xfer && w_we;
            r_addr  <= w_xfer ? w_addr : r_addr;
            r_wdata <= w_xfer ? w_wdata : r_wdata;
            r_s1_v  <= w_xfer && !w_we;
            r_s1_id <= w_gnt1;
            r_s2_v  <= r_s1_v;
            r_s2_id <= r_s1_id;
        end
    end

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign mem_W_EN    = r_w_en;
    assign mem_Address = r_addr;
    assign mem_Data_in = r_wdata;
    assign rvalid0     = r_s2_v && !r_s2_id;
    assign rvalid1     = r_s2_v && r_s2_id;
    assign rdata0      = mem_Data_out;
    assign rdata1      = mem_Data_out;

`ifndef SYNTHESIS
    a_one_hot_gnt : assert property (@(posedge CLK) !(gnt0 && gnt1));
    a_hold0 : assert property (@(posedge CLK) disable iff (RST)
        req0 && !gnt0 |=> !req0 || $stable({we0, addr0, wdata0}));
    a_hold1 : assert property (@(posedge CLK) disable iff (RST)
        req1 && !gnt1 |=> !req1 || $stable({we1, addr1, wdata1}));
`endif
endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb_mem_arbiter_2p: directed checks of mem_arbiter_2p against a behavioural registered-output memory.
module tb_mem_arbiter_2p;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        CLK;
    logic        RST;
    logic        req0, req1, we0, we1;
    logic [3:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [3:0]  mem_Address;
    logic [31:0] mem_Data_in;
    logic        mem_W_EN;
    logic [31:0] mem_Data_out;
    logic [31:0] mem [16];
    bit          mem_init = 1'b0;
    int          n_cmp = 0;
    int          n_fail = 0;

    mem_arbiter_2p #(.ADDR_W(4), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_Address(mem_Address), .mem_Data_in(mem_Data_in),
        .mem_W_EN(mem_W_EN), .mem_Data_out(mem_Data_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents start at 0x1000_0000 + address so wrong-address reads are visible
    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
            mem_Data_out <= 32'h0;
            mem_init <= 1'b1;
        end else begin
            if (mem_W_EN) mem[mem_Address] <= mem_Data_in;
            mem_Data_out <= mem[mem_Address];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {gnt0, gnt1}); end
        n_cmp++;
        if ({mem_W_EN, mem_Address, mem_Data_in} !== 37'h0) begin
            n_fail++; $display("FAIL reset_mem_if: got we=%b a=%h d=%h want 0/0/0", mem_W_EN, mem_Address, mem_Data_in);
        end
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
        req0 = 1'b0; req1 = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({gnt0, gnt1, mem_W_EN} !== 3'b000) begin
                n_fail++; $display("FAIL idle cyc %0d: got gnt=%b%b we=%b want 000", i, gnt0, gnt1, mem_W_EN);
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (mem[i] !== 32'h1000_0000 + i) begin
                n_fail++; $display("FAIL idle_mem[%0d]: got %h want %h", i, mem[i], 32'h1000_0000 + i);
            end
        end
    endtask

    task automatic test_contention();
        int hist [8];
        bit e0, e1;
        logic [1:0]  exp_rv;
        logic [31:0] got_d, exp_d;
        we0 = 1'b0; we1 = 1'b0; addr0 = 4'd1; addr1 = 4'd2;
        for (int i = 0; i < 8; i++) begin
            req0 = (i < 6); req1 = (i < 6);
            #1;
            e0 = (i < 6) && (!RR || (i % 2 == 0));
            e1 = (i < 6) && !e0;
            n_cmp++;
            if ({gnt0, gnt1} !== {e0, e1}) begin
                n_fail++; $display("FAIL contention_gnt cyc %0d: got %b want %b", i, {gnt0, gnt1}, {e0, e1});
            end
            exp_rv = 2'b00;
            if (i >= 2 && hist[i-2] >= 0) exp_rv = (hist[i-2] == 0) ? 2'b10 : 2'b01;
            n_cmp++;
            if ({rvalid0, rvalid1} !== exp_rv) begin
                n_fail++; $display("FAIL contention_rvalid cyc %0d: got %b want %b", i, {rvalid0, rvalid1}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                got_d = exp_rv[1] ? rdata0 : rdata1;
                exp_d = exp_rv[1] ? 32'h1000_0001 : 32'h1000_0002;
                n_cmp++;
                if (got_d !== exp_d) begin
                    n_fail++; $display("FAIL contention_rdata cyc %0d: got %h want %h", i, got_d, exp_d);
                end
            end
            hist[i] = e0 ? 0 : (e1 ? 1 : -1);
            tick();
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        n_cmp++;
        if ({mem_W_EN, mem_Address, mem_Data_in} !== {1'b1, 4'd3, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL wr_issue: got we=%b a=%h d=%h want 1/3/deadbeef", mem_W_EN, mem_Address, mem_Data_in);
        end
        we0 = 1'b0; wdata0 = 32'h0;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL rd_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        req0 = 1'b0;
        n_cmp++;
        if ({mem_W_EN, rvalid0, rvalid1} !== 3'b000) begin
            n_fail++; $display("FAIL rd_early: got we=%b rv=%b%b want 000", mem_W_EN, rvalid0, rvalid1);
        end
        tick();
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid: got %b want 10", {rvalid0, rvalid1}); end
        n_cmp++;
        if (rdata0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", rdata0); end
        tick();
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL rd_one_cycle: got %b want 00", {rvalid0, rvalid1}); end
    endtask

    task automatic test_wrap_end();
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd15; wdata1 = 32'h1;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b01) begin n_fail++; $display("FAIL wrap_wr_gnt: got %b want 01", {gnt0, gnt1}); end
        tick();
        req1 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd15;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL wrap_rd_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        req0 = 1'b0;
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL wrap_early: got %b want 00", {rvalid0, rvalid1}); end
        tick();
        n_cmp++;
        if ({rvalid0, rvalid1, rdata0} !== {2'b10, 32'h1}) begin
            n_fail++; $display("FAIL wrap_read: got rv=%b%b d=%h want 10/00000001", rvalid0, rvalid1, rdata0);
        end
        tick();
    endtask

    task automatic test_reset_drop();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL drop_gnt: got %b want 10", {gnt0, gnt1}); end
        tick();
        RST = 1'b1;
        #1;
        n_cmp++;
        if ({gnt0, gnt1} !== 2'b00) begin n_fail++; $display("FAIL drop_gnt_in_rst: got %b want 00", {gnt0, gnt1}); end
        tick();
        RST = 1'b0; req0 = 1'b0;
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL drop_rvalid: got %b want 00", {rvalid0, rvalid1}); end
        n_cmp++;
        if ({mem_W_EN, mem_Address, mem_Data_in} !== 37'h0) begin
            n_fail++; $display("FAIL drop_mem_if: got we=%b a=%h d=%h want 0/0/0", mem_W_EN, mem_Address, mem_Data_in);
        end
        tick();
        n_cmp++;
        if ({rvalid0, rvalid1} !== 2'b00) begin n_fail++; $display("FAIL drop_rvalid_late: got %b want 00", {rvalid0, rvalid1}); end
    endtask

    initial begin
        RST = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'd0; addr1 = 4'd0; wdata0 = 32'h0; wdata1 = 32'h0;
        repeat (3) tick();
        test_reset();
        tick();
        test_idle();
        test_contention();
        test_write_read();
        test_wrap_end();
        test_reset_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
